// File: rtl/divider_if.sv
`default_nettype none
// ============================================================================
// Module      : divider_if
// Description : Handshake and operand bundle for the iterative divider.
//               master drives start/a/b/divcont and observes busy/done/result;
//               slave is the divider side.
//   start   - request a divide (sampled in IDLE or DONE)
//   a, b    - dividend, divisor (32 bit)
//   divcont - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   busy    - operation in progress
//   done    - one-cycle result-valid pulse
//   result  - quotient or remainder, held until next accepted start
// Revision    : 1.0 - initial release
// ============================================================================
interface divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  divcont;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, a, b, divcont,
        input  busy, done, result
    );

    modport slave (
        input  start, a, b, divcont,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module      : divider
// Description : 32-bit restoring divider with RISC-V M semantics
//               (DIV, DIVU, REM, REMU). Fixed 34-cycle latency: one latch
//               cycle, 32 shift-subtract cycles, one sign-fix cycle.
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - divider_if.slave: start/a/b/divcont in, busy/done/result out
// Revision    : 1.0 - initial release
// ============================================================================
module divider (
    input  wire         clk,
    input  wire         reset,
    divider_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] result_reg;
    logic [5:0]  count;
    logic [31:0] quo;       // shifts dividend out, quotient bits in
    logic [31:0] rem;       // partial remainder (always < divisor once committed)
    logic [31:0] divisor;
    logic        sel_rem;
    logic        neg_q;
    logic        neg_r;

    // Operand magnitudes at latch time; unsigned ops pass straight through.
    logic        signed_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign signed_op = ~bus.divcont[0];
    assign mag_a     = (signed_op && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    assign mag_b     = (signed_op && bus.b[31]) ? (32'd0 - bus.b) : bus.b;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // A zero divisor always succeeds, giving all-ones quotient and the
    // dividend as remainder, which is exactly the RISC-V divide-by-zero result.
    logic [32:0] partial;
    logic [32:0] diff;

    assign partial = {rem, quo[31]};
    assign diff    = partial - {1'b0, divisor};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= 32'd0;
            count      <= 6'd0;
            quo        <= 32'd0;
            rem        <= 32'd0;
            divisor    <= 32'd0;
            sel_rem    <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        quo      <= mag_a;
                        rem      <= 32'd0;
                        divisor  <= mag_b;
                        sel_rem  <= bus.divcont[1];
                        // Quotient sign flips only for a real (non-zero)
                        // divisor; remainder follows the dividend's sign.
                        neg_q    <= signed_op && (bus.b != 32'd0) &&
                                    (bus.a[31] ^ bus.b[31]);
                        neg_r    <= signed_op && bus.a[31];
                        count    <= 6'd0;
                        busy_reg <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end

                RUN: begin
                    if (!diff[32]) begin
                        rem <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= partial[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (sel_rem) begin
                        result_reg <= neg_r ? (32'd0 - rem) : rem;
                    end else begin
                        result_reg <= neg_q ? (32'd0 - quo) : quo;
                    end
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    state    <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider
// Description : Self-checking bench for divider. Directed vector table with
//               hand-computed results plus sequences for operand hold-off,
//               back-to-back starts and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    divider_if bus ();

    divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        bus.a       = a;
        bus.b       = b;
        bus.divcont = op;
        bus.start   = 1'b1;
    endtask

    // Called with start already asserted, away from the rising edge.
    // Checks busy/done over the 33 edges after the start edge, then result.
    // hold=1 keeps start high and scrambles operands during RUN.
    task automatic finish_op(input string name, input logic [31:0] exp, input bit hold);
        logic ok;
        @(posedge clk); #1;           // edge N
        if (!hold) bus.start = 1'b0;
        ok = bus.busy && !bus.done;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (hold && k == 1) begin
                bus.a       = 32'h1234_5678;
                bus.b       = 32'h0000_0003;
                bus.divcont = ~bus.divcont;
            end
            if (hold && k == 30) bus.start = 1'b0;
            ok = ok && bus.busy && !bus.done;
        end
        check({name, "_busy_window"}, {31'd0, ok}, 32'd1);
        @(posedge clk); #1;           // edge N+33
        check({name, "_done"}, {30'd0, bus.done, bus.busy}, 32'd2);
        check(name, bus.result, exp);
    endtask

    initial begin
        logic seen_done;
        total = 0;
        bad   = 0;

        vecs[0]  = '{"divu_100_7",   32'd100,        32'd7,          OP_DIVU, 32'd14};
        vecs[1]  = '{"remu_100_7",   32'd100,        32'd7,          OP_REMU, 32'd2};
        vecs[2]  = '{"div_m7_2",     32'hFFFF_FFF9,  32'd2,          OP_DIV,  32'hFFFF_FFFD};
        vecs[3]  = '{"rem_m7_2",     32'hFFFF_FFF9,  32'd2,          OP_REM,  32'hFFFF_FFFF};
        vecs[4]  = '{"divu_m7_2",    32'hFFFF_FFF9,  32'd2,          OP_DIVU, 32'h7FFF_FFFC};
        vecs[5]  = '{"div_by0",      32'hFFFF_FFFB,  32'd0,          OP_DIV,  32'hFFFF_FFFF};
        vecs[6]  = '{"rem_by0",      32'hFFFF_FFFB,  32'd0,          OP_REM,  32'hFFFF_FFFB};
        vecs[7]  = '{"remu_by0",     32'hFFFF_FFFB,  32'd0,          OP_REMU, 32'hFFFF_FFFB};
        vecs[8]  = '{"divu_by0",     32'hFFFF_FFFB,  32'd0,          OP_DIVU, 32'hFFFF_FFFF};
        vecs[9]  = '{"div_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  OP_DIV,  32'h8000_0000};
        vecs[10] = '{"rem_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  OP_REM,  32'h0000_0000};
        vecs[11] = '{"div_100_m7",   32'd100,        32'hFFFF_FFF9,  OP_DIV,  32'hFFFF_FFF2};
        vecs[12] = '{"rem_100_m7",   32'd100,        32'hFFFF_FFF9,  OP_REM,  32'd2};
        vecs[13] = '{"rem_m100_7",   32'hFFFF_FF9C,  32'd7,          OP_REM,  32'hFFFF_FFFE};
        vecs[14] = '{"divu_max_1",   32'hFFFF_FFFF,  32'd1,          OP_DIVU, 32'hFFFF_FFFF};
        vecs[15] = '{"remu_5_10",    32'd5,          32'd10,         OP_REMU, 32'd5};

        bus.start   = 1'b0;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.divcont = 2'b00;
        reset       = 1'b0;

        // Reset state, with a start request that must be ignored.
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check("rst_done",   {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result,        32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            launch(vecs[i].a, vecs[i].b, vecs[i].op);
            finish_op(vecs[i].name, vecs[i].exp, 1'b0);
            @(posedge clk); #1;
            check({vecs[i].name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
            check({vecs[i].name, "_held"}, bus.result, vecs[i].exp);
        end

        // Start held high and operands changed during RUN: no restart.
        @(negedge clk);
        launch(32'd100, 32'd7, OP_DIVU);
        finish_op("hold_divu", 32'd14, 1'b1);

        // Back-to-back: second start during DONE, no idle cycle.
        @(negedge clk);
        launch(32'd1000, 32'd9, OP_DIVU);
        finish_op("b2b_first", 32'd111, 1'b0);
        launch(32'd1000, 32'd9, OP_REMU);   // still in DONE cycle
        finish_op("b2b_second", 32'd1, 1'b0);
        @(posedge clk); #1;

        // Reset during the 10th RUN cycle.
        @(negedge clk);
        launch(32'd100, 32'd7, OP_DIVU);
        @(posedge clk); #1;                 // edge N
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_pre_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy",   {31'd0, bus.busy}, 32'd0);
        check("mid_rst_result", bus.result,        32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen_done = 1'b1;
        end
        check("mid_rst_no_done", {31'd0, seen_done}, 32'd0);

        // Start held through reset: taken on the first edge after release.
        @(negedge clk);
        reset = 1'b0;
        launch(32'hFFFF_FFF9, 32'd2, OP_DIV);
        @(posedge clk); #1;
        check("rst_start_ignored", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        finish_op("post_rst_div", 32'hFFFF_FFFD, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE or DONE.
REQ-004 SHALL have port a, input, 32 bits: dividend.
REQ-005 SHALL have port b, input, 32 bits: divisor.
REQ-006 SHALL have port divcont, input, 2 bits: operation select; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 SHALL have port result, output, 32 bits: quotient or remainder; held until the next accepted start.

Function
REQ-010 SHALL implement states IDLE, RUN, FIX and DONE.
REQ-011 SHALL accept start in IDLE or DONE on edge N, latch a, b and divcont, and enter RUN.
REQ-012 SHALL, for signed ops (divcont[0]=0), convert a and b to 32-bit unsigned magnitudes at latch; for unsigned ops it SHALL use them unchanged.
REQ-013 SHALL, in RUN, perform one restoring shift-subtract step per cycle, using a 33-bit partial remainder and a 6-bit iteration counter.
REQ-014 SHALL run exactly 32 RUN cycles (edges N+1..N+32), then enter FIX.
REQ-015 SHALL, in FIX (edge N+33), apply sign correction.
- Quotient: negated when signed, b!=0 and a[31]^b[31]=1.
- Remainder: negated when signed and a[31]=1.
REQ-016 SHALL load result at edge N+33, select quotient (divcont[1]=0) or remainder (divcont[1]=1), and enter DONE.
REQ-017 SHALL drive done=1 only in DONE (one cycle) and return to IDLE on the next edge unless start=1.
REQ-018 SHALL, if start=1 in DONE, accept it as in REQ-011; back-to-back operations have no idle bubble.
REQ-019 SHALL drive busy=1 in RUN and FIX only.
REQ-020 SHALL keep a fixed latency of 34 cycles from the start edge to done, for all operand values including special cases.
REQ-021 SHALL ignore start while busy=1, and ignore changes on a, b and divcont after latch.
REQ-022 SHALL handle division by zero (b=0) per RISC-V M.
- Quotient: 0xFFFFFFFF for DIV and DIVU.
- Remainder: a unchanged for REM and REMU.
REQ-023 SHALL handle signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM) by returning quotient 0x80000000 and remainder 0.
REQ-024 SHALL never leave result partially updated; result changes only at the FIX edge or on reset.

Reset
REQ-025 SHALL, while reset=0, asynchronously force state IDLE, busy=0, done=0, result=0 and counter=0.
REQ-026 SHALL abandon any in-flight operation on reset assertion, with no done pulse afterwards.
REQ-027 SHALL not accept a start coinciding with reset=0.
REQ-028 SHALL accept start on the first rising edge after reset returns to 1.

Verification
REQ-029 SHALL cover DIVU a=100, b=7, start at edge N -> busy=1 for N+1..N+33; done=1 after edge N+33; result=14; REMU -> 2.
REQ-030 SHALL cover signed ops a=0xFFFFFFF9 (-7), b=2 -> DIV=0xFFFFFFFD (-3); REM=0xFFFFFFFF (-1); DIVU=0x7FFFFFFC.
REQ-031 SHALL cover divide by zero a=0xFFFFFFFB (-5), b=0 -> DIV=0xFFFFFFFF; REM=0xFFFFFFFB; REMU=0xFFFFFFFB; latency still 34.
REQ-032 SHALL cover overflow a=0x80000000, b=0xFFFFFFFF -> DIV=0x80000000; REM=0x00000000.
REQ-033 SHALL cover start held high and operands changed during RUN -> no restart; result reflects the originally latched operands.
REQ-034 SHALL cover back-to-back start in DONE -> the second op begins with no bubble.
REQ-035 SHALL cover reset=0 at the 10th RUN cycle -> busy=0, result=0 immediately; no done pulse; the next start completes normally.
